pid_ctrl_pipe: RTL and testbench

Parametrised, pipelined PID steering controller: the next generation of the fixed-width PID block. Turns a signed heading error and an unsigned forward speed into signed left/right motor speed commands. Adds configurable gains, widths and derivative history depth, integrator anti-windup, output saturation and an explicit output-valid strobe. Sits between the heading-error source and the motor PWM drive.

---
 rtl/pid_pkg.sv | 34 +++
 rtl/pid_dterm.sv | 37 +++
 rtl/pid_ctrl_pipe.sv | 109 ++++++++++
 tb/tb_pid_ctrl_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared widths, stage-1 payload type and saturation helper for the PID controller.
package pid_pkg;

    localparam int unsigned ERR_SAT_W = 10;
    localparam int unsigned DIFF_W    = 8;
    localparam int unsigned SUM_W     = 15;
    localparam int unsigned COEFF_W   = 6;
    localparam int unsigned P_W       = ERR_SAT_W + COEFF_W;
    localparam int unsigned D_W       = DIFF_W + COEFF_W;

    // Stage-1 registered terms
    typedef struct packed {
        logic signed [P_W-1:0] p;
        logic signed [D_W-1:0] d;
    } s1_t;

    // Clamp a signed value to the range of a w-bit two's-complement number
    function automatic logic signed [31:0] sat_to_width(
        input logic signed [31:0] v,
        input int unsigned        w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/pid_dterm.sv
// Derivative term: error history shift register, saturated difference and D multiply.
module pid_dterm
    import pid_pkg::*;
#(
    parameter int unsigned                D_DEPTH = 2,
    parameter logic signed [COEFF_W-1:0]  D_COEFF = 6'sd5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         shift,
    input  logic signed [ERR_SAT_W-1:0]  err_sat,
    output logic signed [D_W-1:0]        d_val
);

    logic signed [ERR_SAT_W-1:0] hist [D_DEPTH];
    logic signed [DIFF_W-1:0]    diff;

    // History of accepted samples; cleared by reset or when the controller stops
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int unsigned i = 0; i < D_DEPTH; i++)
                hist[i] <= '0;
        end else if (shift) begin
            hist[0] <= err_sat;
            for (int unsigned i = 1; i < D_DEPTH; i++)
                hist[i] <= hist[i-1];
        end
    end

    // Difference against the oldest stored sample, clamped, then scaled by the gain
    always_comb begin
        diff  = DIFF_W'(sat_to_width(32'(err_sat) - 32'(hist[D_DEPTH-1]), DIFF_W));
        d_val = D_W'(diff) * D_W'(D_COEFF);
    end

endmodule

// File: rtl/pid_ctrl_pipe.sv
// Two-stage pipelined PID steering controller with anti-windup and output saturation.
module pid_ctrl_pipe
    import pid_pkg::*;
#(
    parameter int unsigned               ERR_W   = 12,
    parameter int unsigned               FRWRD_W = 10,
    parameter int unsigned               SPD_W   = 11,
    parameter logic signed [COEFF_W-1:0] P_COEFF = 6'sd3,
    parameter logic signed [COEFF_W-1:0] D_COEFF = 6'sd5,
    parameter int unsigned               D_DEPTH = 2,
    parameter int unsigned               INT_W   = 16,
    parameter int unsigned               I_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     moving,
    input  logic                     err_vld,
    input  logic signed [ERR_W-1:0]  error,
    input  logic [FRWRD_W-1:0]       frwrd,
    output logic signed [SPD_W-1:0]  lft_spd,
    output logic signed [SPD_W-1:0]  rght_spd,
    output logic                     out_vld
);

    logic                        upd;
    logic signed [ERR_SAT_W-1:0] err_sat;
    logic signed [P_W-1:0]       p_val;
    logic signed [D_W-1:0]       d_val;
    logic signed [INT_W-1:0]     integ;
    logic signed [INT_W-1:0]     es_ext;
    logic signed [INT_W-1:0]     cand;
    logic                        ovf;
    logic signed [INT_W-1:0]     i_term;
    s1_t                         s1_q;
    logic                        s1_vld;
    logic signed [SUM_W-1:0]     pid;
    logic signed [31:0]          lft_full;
    logic signed [31:0]          rght_full;
    logic signed [SPD_W-1:0]     lft_nxt;
    logic signed [SPD_W-1:0]     rght_nxt;

    pid_dterm #(
        .D_DEPTH (D_DEPTH),
        .D_COEFF (D_COEFF)
    ) u_dterm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!moving),
        .shift   (upd),
        .err_sat (err_sat),
        .d_val   (d_val)
    );

    // Stage-1 combinational: input clamp, P term and integrator candidate
    always_comb begin
        upd     = err_vld && moving;
        err_sat = ERR_SAT_W'(sat_to_width(32'(error), ERR_SAT_W));
        p_val   = P_W'(err_sat) * P_W'(P_COEFF);
        es_ext  = INT_W'(err_sat);
        cand    = integ + es_ext;
        ovf     = (integ[INT_W-1] == es_ext[INT_W-1]) && (cand[INT_W-1] != integ[INT_W-1]);
    end

    // Integrator with anti-windup: an overflowing update is discarded, never wrapped
    always_ff @(posedge clk) begin
        if (!rst_n || !moving)
            integ <= '0;
        else if (err_vld && !ovf)
            integ <= cand;
    end

    // Stage-1 registers: P and D terms plus the stage valid
    always_ff @(posedge clk) begin
        if (!rst_n || !moving) begin
            s1_q   <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= err_vld;
            if (err_vld)
                s1_q <= '{p: p_val, d: d_val};
        end
    end

    // Stage-2 combinational: I from the live integrator, PID sum and motor mixing
    always_comb begin
        i_term    = integ >>> I_SHIFT;
        pid       = SUM_W'(s1_q.p) + SUM_W'(i_term) + SUM_W'(s1_q.d);
        lft_full  = 32'(frwrd) + 32'(pid);
        rght_full = 32'(frwrd) - 32'(pid);
        lft_nxt   = SPD_W'(sat_to_width(lft_full, SPD_W));
        rght_nxt  = SPD_W'(sat_to_width(rght_full, SPD_W));
    end

    // Stage-2 registers: outputs hold between updates, forced to zero when stopped
    always_ff @(posedge clk) begin
        if (!rst_n || !moving) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            out_vld  <= 1'b0;
        end else begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                lft_spd  <= lft_nxt;
                rght_spd <= rght_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// Directed self-checking bench for pid_ctrl_pipe at default parameters.
module tb_pid_ctrl_pipe;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                moving;
    logic                err_vld;
    logic signed [11:0]  error;
    logic [9:0]          frwrd;
    logic signed [10:0]  lft_spd;
    logic signed [10:0]  rght_spd;
    logic                out_vld;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pid_ctrl_pipe #(
        .ERR_W   (12),
        .FRWRD_W (10),
        .SPD_W   (11),
        .P_COEFF (6'sd3),
        .D_COEFF (6'sd5),
        .D_DEPTH (2),
        .INT_W   (16),
        .I_SHIFT (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .moving   (moving),
        .err_vld  (err_vld),
        .error    (error),
        .frwrd    (frwrd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .out_vld  (out_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; moving = 1'b1; err_vld = 1'b0; error = '0; frwrd = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; moving = 1'b1; err_vld = 1'b1; error = 12'sd100; frwrd = 10'd256;
        tick(); tick();
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld: got %0d expected 0", out_vld); end
        checks++; if (lft_spd !== 11'sd0) begin failures++; $display("FAIL reset_lft: got %0d expected 0", lft_spd); end
        checks++; if (rght_spd !== 11'sd0) begin failures++; $display("FAIL reset_rght: got %0d expected 0", rght_spd); end
        checks++; if (dut.integ !== 16'sd0) begin failures++; $display("FAIL reset_integ: got %0d expected 0", dut.integ); end
        err_vld = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_zero_error();
        do_reset();
        frwrd = 10'd256; error = 12'sd0; err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL zero_early_vld: got %0d expected 0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL zero_vld: got %0d expected 1", out_vld); end
        checks++; if (lft_spd !== 11'sd256) begin failures++; $display("FAIL zero_lft: got %0d expected 256", lft_spd); end
        checks++; if (rght_spd !== 11'sd256) begin failures++; $display("FAIL zero_rght: got %0d expected 256", rght_spd); end
        tick();
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL zero_vld_pulse: got %0d expected 0", out_vld); end
        checks++; if (lft_spd !== 11'sd256) begin failures++; $display("FAIL zero_lft_hold: got %0d expected 256", lft_spd); end
    endtask

    task automatic test_single_sat();
        do_reset();
        frwrd = 10'd256; error = 12'sd100; err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        tick();
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL single_vld: got %0d expected 1", out_vld); end
        checks++; if (lft_spd !== 11'sd1023) begin failures++; $display("FAIL single_lft: got %0d expected 1023", lft_spd); end
        checks++; if (rght_spd !== -11'sd550) begin failures++; $display("FAIL single_rght: got %0d expected -550", rght_spd); end
    endtask

    task automatic test_input_sat();
        do_reset();
        frwrd = 10'd0; error = 12'sd2047; err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        tick();
        checks++; if (lft_spd !== 11'sd1023) begin failures++; $display("FAIL insat_lft: got %0d expected 1023", lft_spd); end
        checks++; if (rght_spd !== -11'sd1024) begin failures++; $display("FAIL insat_rght: got %0d expected -1024", rght_spd); end
    endtask

    // error -20, frwrd 300: P=-60, I=-20>>>4=-2, D=-100, PID=-162
    task automatic test_negative();
        do_reset();
        frwrd = 10'd300; error = -12'sd20; err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        tick();
        checks++; if (lft_spd !== 11'sd138) begin failures++; $display("FAIL neg_lft: got %0d expected 138", lft_spd); end
        checks++; if (rght_spd !== 11'sd462) begin failures++; $display("FAIL neg_rght: got %0d expected 462", rght_spd); end
    endtask

    // errors 10,20,30 back to back: PID 80, 161, 193
    task automatic test_back_to_back();
        do_reset();
        frwrd = 10'd0; err_vld = 1'b1;
        error = 12'sd10; tick();
        error = 12'sd20; tick();
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL b2b_vld1: got %0d expected 1", out_vld); end
        checks++; if (lft_spd !== 11'sd80) begin failures++; $display("FAIL b2b_lft1: got %0d expected 80", lft_spd); end
        error = 12'sd30; tick();
        err_vld = 1'b0;
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL b2b_vld2: got %0d expected 1", out_vld); end
        checks++; if (lft_spd !== 11'sd161) begin failures++; $display("FAIL b2b_lft2: got %0d expected 161", lft_spd); end
        tick();
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL b2b_vld3: got %0d expected 1", out_vld); end
        checks++; if (lft_spd !== 11'sd193) begin failures++; $display("FAIL b2b_lft3: got %0d expected 193", lft_spd); end
        checks++; if (rght_spd !== -11'sd193) begin failures++; $display("FAIL b2b_rght3: got %0d expected -193", rght_spd); end
        tick();
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL b2b_vld_end: got %0d expected 0", out_vld); end
    endtask

    task automatic test_anti_windup();
        do_reset();
        frwrd = 10'd0; error = -12'sd512; err_vld = 1'b1;
        repeat (64) tick();
        checks++; if (dut.integ !== -16'sd32768) begin failures++; $display("FAIL windup_64: got %0d expected -32768", dut.integ); end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (dut.integ !== -16'sd32768) begin failures++; $display("FAIL windup_hold[%0d]: got %0d expected -32768", i, dut.integ); end
            checks++; if (lft_spd !== -11'sd1024 || rght_spd !== 11'sd1023) begin
                failures++; $display("FAIL windup_out[%0d]: got %0d/%0d expected -1024/1023", i, lft_spd, rght_spd);
            end
        end
        err_vld = 1'b0;
        tick();
    endtask

    task automatic test_moving_clear();
        error = 12'sd50; frwrd = 10'd100; err_vld = 1'b1;
        tick(); tick();
        moving = 1'b0;
        tick();
        checks++; if (lft_spd !== 11'sd0 || rght_spd !== 11'sd0) begin failures++; $display("FAIL clr_out: got %0d/%0d expected 0/0", lft_spd, rght_spd); end
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL clr_vld: got %0d expected 0", out_vld); end
        checks++; if (dut.integ !== 16'sd0) begin failures++; $display("FAIL clr_integ: got %0d expected 0", dut.integ); end
        moving = 1'b1; err_vld = 1'b0;
        tick();
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL clr_stray_vld: got %0d expected 0", out_vld); end
        error = 12'sd0; frwrd = 10'd0; err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        tick();
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL restart_vld: got %0d expected 1", out_vld); end
        checks++; if (lft_spd !== 11'sd0 || rght_spd !== 11'sd0) begin failures++; $display("FAIL restart_out: got %0d/%0d expected 0/0", lft_spd, rght_spd); end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        frwrd = 10'd256; error = 12'sd100; err_vld = 1'b1;
        tick();
        err_vld = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rif_vld0: got %0d expected 0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rif_vld1: got %0d expected 0", out_vld); end
        checks++; if (lft_spd !== 11'sd0 || rght_spd !== 11'sd0) begin failures++; $display("FAIL rif_out: got %0d/%0d expected 0/0", lft_spd, rght_spd); end
        tick();
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rif_vld2: got %0d expected 0", out_vld); end
    endtask

    initial begin
        test_reset();
        test_zero_error();
        test_single_sat();
        test_input_sat();
        test_negative();
        test_back_to_back();
        test_anti_windup();
        test_moving_clear();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
